// File: rtl/subtractor_serial_handshake.sv
// subtractor_serial_handshake: bit-serial a-b-bin subtractor, LSB first, start/done handshake
module subtractor_serial_handshake #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sa, sb, res, res_n;
  logic [CW-1:0]    cnt;
  logic             br, d, br_n;
  assign d     = sa[0] ^ sb[0] ^ br;
  assign br_n  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign res_n = {d, res[WIDTH-1:1]};
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          br    <= bin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_n;
          br  <= br_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff   <= res_n;
            borrow <= br_n;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
